// File: rtl/rnn_fixed_pkg.sv
// Fixed-point format shared by the LSTM datapath stages: Q6.11 word layout,
// saturation bounds, rounding constant and the MAC sequencing states.
package rnn_fixed_pkg;

    localparam int QN       = 6;
    localparam int QM       = 11;
    localparam int BITWIDTH = QN + QM + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    function automatic longint fx_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic longint fx_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    function automatic longint fx_half(input int qm);
        return 64'sd1 <<< (qm - 1);
    endfunction

    localparam longint FX_MAX  = fx_max(BITWIDTH);
    localparam longint FX_MIN  = fx_min(BITWIDTH);
    localparam longint FX_HALF = fx_half(QM);

endpackage

// File: rtl/fx_round_sat.sv
// Reduces a wide fixed-point sum to one output word: round half up,
// arithmetic shift by the fractional width, clamp to the word range.
module fx_round_sat
    import rnn_fixed_pkg::*;
#(
    parameter int     IN_W    = 2 * BITWIDTH + 3,
    parameter int     FRAC    = QM,
    parameter int     OUT_W   = BITWIDTH,
    parameter longint SAT_MAX = FX_MAX,
    parameter longint SAT_MIN = FX_MIN,
    parameter longint HALF    = FX_HALF
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] rounded
);

    localparam logic signed [IN_W:0] HALF_EXT = (IN_W + 1)'(HALF);
    localparam logic signed [IN_W:0] MAX_EXT  = (IN_W + 1)'(SAT_MAX);
    localparam logic signed [IN_W:0] MIN_EXT  = (IN_W + 1)'(SAT_MIN);

    logic signed [IN_W:0] biased_s;
    logic signed [IN_W:0] shifted_s;

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    always_comb begin
        biased_s  = $signed({value[IN_W-1], value}) + HALF_EXT;
        shifted_s = biased_s >>> FRAC;
        if (shifted_s > MAX_EXT) begin
            rounded = OUT_W'(SAT_MAX);
        end else if (shifted_s < MIN_EXT) begin
            rounded = OUT_W'(SAT_MIN);
        end else begin
            rounded = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/gate_preact_mac.sv
// LSTM gate pre-activation: bias plus N_ELEM streamed products, accumulated at
// full precision, then rounded/saturated and held for the sigmoid stage.
module gate_preact_mac
    import rnn_fixed_pkg::*;
#(
    parameter int QN     = rnn_fixed_pkg::QN,
    parameter int QM     = rnn_fixed_pkg::QM,
    parameter int N_ELEM = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [QN+QM:0]    bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [QN+QM:0]    weight,
    input  logic signed [QN+QM:0]    data,
    output logic signed [QN+QM:0]    result,
    output logic                     out_valid
);

    localparam int BW = QN + QM + 1;
    localparam int PW = 2 * BW;
    localparam int AW = PW + $clog2(N_ELEM) + 1;
    localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_ELEM - 1);

    mac_state_t            state_r;
    mac_state_t            state_s;
    logic                  start_ok_s;
    logic                  beat_s;
    logic                  done_hold_r;
    logic [CW-1:0]         count_r;
    logic signed [AW-1:0]  acc_r;
    logic signed [PW-1:0]  product_s;
    logic signed [BW-1:0]  rounded_s;
    logic signed [BW-1:0]  result_r;
    logic                  out_valid_r;

    assign in_ready  = (state_r == ST_ACC);
    assign beat_s    = in_valid && in_ready;
    assign product_s = PW'(weight) * PW'(data);
    assign result    = result_r;
    assign out_valid = out_valid_r;

    // Next-state logic; a start in DONE waits until the result has been shown one full cycle.
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    state_s    = ST_ACC;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_s && (count_r == LAST_BEAT)) begin
                    state_s = ST_ROUND;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_ROUND: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                if (start && done_hold_r) begin
                    start_ok_s = 1'b1;
                    state_s    = ST_ACC;
                end else begin
                    state_s    = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the flag marking the second and later DONE cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            done_hold_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            done_hold_r <= (state_r == ST_DONE);
        end
    end

    // Accumulator and beat counter: bias preload on start, one product per accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r   <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (start_ok_s) begin
            acc_r   <= AW'(bias) <<< QM;
            count_r <= {CW{1'b0}};
        end else if (beat_s) begin
            acc_r   <= acc_r + AW'(product_s);
            count_r <= count_r + CW'(1);
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    fx_round_sat #(
        .IN_W    (AW),
        .FRAC    (QM),
        .OUT_W   (BW),
        .SAT_MAX (fx_max(BW)),
        .SAT_MIN (fx_min(BW)),
        .HALF    (fx_half(QM))
    ) u_round_sat (
        .value   (acc_r),
        .rounded (rounded_s)
    );

    // Output registers: result only changes in ROUND, so it survives the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r    <= {BW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (state_r == ST_ROUND) begin
            result_r    <= rounded_s;
            out_valid_r <= 1'b1;
        end else if (start_ok_s) begin
            result_r    <= result_r;
            out_valid_r <= 1'b0;
        end else begin
            result_r    <= result_r;
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_gate_preact_mac.sv
// Randomized and directed bench for gate_preact_mac against an arithmetic
// reference of bias*2^QM + sum(w*d), rounded half up and clamped.
module tb_gate_preact_mac;

    localparam int QM = 11;
    localparam int BW = 18;
    localparam int N  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [BW-1:0] bias;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [BW-1:0] weight;
    logic signed [BW-1:0] data;
    logic signed [BW-1:0] result;
    logic                 out_valid;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_prev = 0;
    longint jw[N];
    longint jd[N];

    gate_preact_mac #(.QN(6), .QM(QM), .N_ELEM(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .data      (data),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model_preact(input longint b);
        longint sum;
        longint lim;
        sum = b * (64'sd1 <<< QM);
        for (int i = 0; i < N; i++) sum += jw[i] * jd[i];
        sum = (sum + (64'sd1 <<< (QM - 1))) >>> QM;
        lim = 64'sd1 <<< (BW - 1);
        if (sum > lim - 64'sd1) sum = lim - 64'sd1;
        if (sum < -lim) sum = -lim;
        return sum;
    endfunction

    function automatic logic noise_bit(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(1, 0));
        return 1'b0;
    endfunction

    function automatic longint rnd_val(input bit wide);
        if (wide) return longint'($urandom_range(262143, 0)) - 64'sd131072;
        return longint'($urandom_range(8191, 0)) - 64'sd4096;
    endfunction

    // gap < 0 picks a random 0..3 cycle stall before each beat; noise drives stray start/in_valid.
    task automatic run_job(input string tag, input longint b, input int gap, input int noise);
        longint exp;
        int     g;
        exp   = model_preact(b);
        bias  = BW'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        bias  = BW'($urandom);
        chk_eq("acc_ready", in_ready, 1);
        chk_eq("acc_ov_low", out_valid, 0);
        chk_eq("acc_hold_result", result, exp_prev);
        for (int i = 0; i < N; i++) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                weight   = BW'($urandom);
                start    = noise_bit(noise);
                step();
                start    = 1'b0;
                chk_eq("stall_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            weight   = BW'(jw[i]);
            data     = BW'(jd[i]);
            step();
            in_valid = 1'b0;
        end
        chk_eq("round_ready", in_ready, 0);
        chk_eq("round_ov_low", out_valid, 0);
        start    = noise_bit(noise);
        in_valid = noise_bit(noise);
        weight   = BW'($urandom);
        data     = BW'($urandom);
        step();
        chk_eq(tag, result, exp);
        chk_eq("ov_rise", out_valid, 1);
        start = noise_bit(noise);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk_eq("done_result", result, exp);
        chk_eq("done_ov", out_valid, 1);
        chk_eq("done_ready", in_ready, 0);
        exp_prev = exp;
    endtask

    task automatic load_nominal();
        for (int i = 0; i < N; i++) begin
            jw[i] = 64'sd2048;
            jd[i] = 64'sd2048 * longint'(i + 1);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        bias     = '0;
        in_valid = 1'b0;
        weight   = '0;
        data     = '0;
        #1;
        chk_eq("reset_result", result, 0);
        chk_eq("reset_ov", out_valid, 0);
        chk_eq("reset_ready", in_ready, 0);
        step();
        step();
        reset = 1'b1;

        in_valid = 1'b1;
        weight   = 18'sd77;
        data     = 18'sd99;
        step();
        in_valid = 1'b0;
        chk_eq("idle_ready", in_ready, 0);
        chk_eq("idle_ov", out_valid, 0);

        load_nominal();
        run_job("nominal", 64'sd1024, 0, 0);

        for (int i = 0; i < N; i++) begin jw[i] = 64'sd63488; jd[i] = 64'sd63488; end
        run_job("sat_pos", 64'sd0, 0, 0);
        for (int i = 0; i < N; i++) jd[i] = -64'sd63488;
        run_job("sat_neg", 64'sd0, 0, 0);

        for (int i = 0; i < N; i++) begin jw[i] = 64'sd0; jd[i] = 64'sd0; end
        jw[2] = 64'sd1;
        jd[2] = 64'sd1024;
        run_job("round_up", 64'sd0, 0, 0);
        jd[2] = -64'sd1024;
        run_job("round_half_neg", 64'sd0, 0, 0);
        jd[2] = -64'sd1025;
        run_job("round_below_neg", 64'sd0, 0, 0);

        load_nominal();
        run_job("stall_ignored_start", 64'sd1024, 3, 2);
        run_job("second_done_start", 64'sd1024, 0, 0);

        // Reset in the middle of an accumulation, after two beats.
        bias  = 18'sd1024;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            weight   = BW'(jw[i]);
            data     = BW'(jd[i]);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_eq("midreset_result", result, 0);
        chk_eq("midreset_ov", out_valid, 0);
        chk_eq("midreset_ready", in_ready, 0);
        step();
        reset    = 1'b1;
        exp_prev = 0;
        run_job("after_reset", 64'sd1024, 0, 0);

        for (int t = 0; t < 40; t++) begin
            bit wide;
            longint b;
            wide = 1'($urandom_range(1, 0));
            b    = rnd_val(wide);
            for (int i = 0; i < N; i++) begin
                jw[i] = rnd_val(wide);
                jd[i] = rnd_val(wide);
            end
            run_job("random", b, -1, 1);
            if ($urandom_range(3, 0) == 0) begin
                step();
                chk_eq("idle_done_result", result, exp_prev);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_preact_mac.md
# gate_preact_mac

Upstream feeder for the `sigmoid` activation stage. Computes one LSTM gate pre-activation `z = b + Σ w[i]·x[i]` over `N_ELEM` streamed weight/data pairs in Q`QN`.`QM`. Accumulation is full precision, then the sum is rounded and saturated to one `QN+QM+1`-bit word. The result is held stable on `result` so `sigmoid` can consume it across its two-cycle evaluation.

## Interface
- `QN`, default 6: integer bits, excluding sign.
- `QM`, default 11: fractional bits.
- `N_ELEM`, default 4: products per pre-activation, ≥1.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begins a new pre-activation and samples `bias`.
- `bias` in `QN+QM+1` signed: gate bias, sampled on an accepted `start`.
- `in_valid` in 1: `weight`/`data` pair present.
- `in_ready` out 1: block accepts a pair this cycle.
- `weight` in `QN+QM+1` signed: weight element.
- `data` in `QN+QM+1` signed: input or hidden-state element.
- `result` out `QN+QM+1` signed: rounded, saturated pre-activation. Drives `sigmoid.operand`.
- `out_valid` out 1: `result` holds a completed pre-activation.

## Operation
- Widths:
  - BW = `QN+QM+1` = 18.
  - Product is 2·BW = 36 bits signed.
  - Accumulator is 2·BW + clog2(N_ELEM) + 1 bits signed.
- States:
  - IDLE: leave on accepted `start` → ACC.
  - ACC: each accepted beat adds the product; final beat → ROUND.
  - ROUND: exactly 1 cycle → DONE.
  - DONE: accepted `start` → ACC.
- Accepted `start`:
  - Only in IDLE, or in DONE once `out_valid` has been high ≥2 cycles.
  - Accumulator ← `bias` sign-extended and shifted left by `QM`.
  - Beat count ← 0; `out_valid` ← 0.
  - `result` keeps its old value.
- `start` in ACC, in ROUND, or in the first DONE cycle is ignored. No error is flagged.
- `in_ready` = (state == ACC), combinational from state.
- Beat accepted when `in_valid && in_ready`: accumulator += `weight`·`data`, count += 1.
- `in_valid` outside ACC is ignored. Gaps in `in_valid` stall the accumulation with no loss.
- ROUND performs these steps in order:
  1. Add 2^(QM−1) to the accumulator (round half up, toward +∞).
  2. Arithmetic shift right by `QM`.
  3. Clamp to [−2^(BW−1), 2^(BW−1)−1], i.e. [−131072, 131071] raw.
  4. Register the value into `result` and set `out_valid` ← 1.
- DONE holds `result` and `out_valid` constant until an accepted `start`.
- Reset asserted, at any time including mid-accumulation:
  - State → IDLE.
  - Accumulator, count, `result` → 0.
  - `out_valid` → 0.
  - Partial sums are discarded.

## Timing
- The final beat is accepted at edge k.
- The ROUND state occupies cycle k→k+1.
- `result` and `out_valid` update at edge k+1.
- Minimum start-to-`out_valid` time, with no stalls: N_ELEM+1 edges after the edge that accepts `start`.
- `result` is stable ≥2 consecutive cycles after `out_valid` rises. This covers both `sigmoid` phases regardless of its phase alignment.
- Minimum back-to-back period: N_ELEM+3 cycles.
- `N_ELEM` = 1: ACC lasts exactly one accepted beat.
- Reset deassertion is synchronized externally. The first `start` may be accepted on the first edge after deassertion.

## Structure
- Shared package `rnn_fixed_pkg` holds:
  - `QN`, `QM`, `BITWIDTH`.
  - Saturation bounds `FX_MAX`/`FX_MIN`.
  - Rounding constant `FX_HALF`.
  - The state encoding typedef.
- All datapath stages use `rnn_fixed_pkg`.
- One sub-module, `fx_round_sat`:
  - Combinational, parameterised by input width.
  - Performs round-half-up, arithmetic shift by `QM`, and clamp.
  - Instantiated in the ROUND path; reusable by the cell-state adder.
- The top level contains only the FSM, the beat counter, the accumulator and the output registers.

## Test plan
- Nominal sum, `N_ELEM` = 4:
  - Stimulus: `bias` = 1024 (0.5); `weight` = 2048 on every beat; `data` = 2048, 4096, 6144, 8192.
  - Required: `result` = 21504 (10.5); `out_valid` at edge 5 after `start`.
- Positive saturation:
  - Stimulus: `bias` = 0; `weight` = `data` = 63488 (31.0) on all four beats.
  - Required: `result` = 131071.
- Negative saturation:
  - Stimulus: as above but `data` = −63488.
  - Required: `result` = −131072.
- Rounding, `bias` = 0, three beats of zero plus one beat as follows:
  - `weight` = 1, `data` = 1024 → `result` = 1.
  - `weight` = 1, `data` = −1024 → `result` = 0.
  - `weight` = 1, `data` = −1025 → `result` = −1.
- Stall and ignored-start handling:
  - Stimulus: the nominal vectors with 3-cycle `in_valid` gaps, `start` pulsed during ACC, ROUND and the first DONE cycle.
  - Required: `result` = 21504; those starts have no effect; a `start` in the second DONE cycle is accepted.
- Reset mid-operation:
  - Stimulus: drive `reset` low after 2 beats, then release and run the nominal vectors.
  - Required: all outputs read 0 immediately on assertion; the next run yields 21504.
